// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct constants,
// ALU control codes, FSM state encodings and the per-state control word.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_OFF forces alucontrol to 000 so IDLE/illegal states drive all-zero outputs
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OFF   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       retire;
    logic       mem_gate;    // irwrite/pcwrite/retire qualified by mem_ready
    logic       chk_opcode;  // flag unknown opcodes as illegal in this state
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb  = 2'b01;
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.mem_gate = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb    = 2'b11;
        c.chk_opcode = 1'b1;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.retire   = 1'b1;
        c.mem_gate = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
        c.retire  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
        c.retire  = 1'b1;
      end
      default: c.aluop = ALUOP_OFF;
    endcase
    return c;
  endfunction

  function automatic logic opcode_known(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, retire, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, retire, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's aluop and the instruction funct field to an ALU control code.
module alu_decoder
  import mips_defs::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal_funct
);

  always_comb begin
    alucontrol    = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath; the control word is registered
// from the next state, only mem_ready gating, zero and illegal detection are combinational.
module multicycle_controller
  import mips_defs::*;
#(
  parameter int STATE_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  if (STATE_W != $bits(state_e)) begin : g_state_w_check
    $error("STATE_W must match the width of state_e");
  end

  state_e     state_reg;
  state_e     state_next;
  ctrl_t      ctrl_reg;
  logic       mem_ok;
  logic       gate_ok;
  logic [2:0] alu_ctl;
  logic       illegal_funct;

  if (MEM_WAIT_EN) begin : g_mem_wait
    assign mem_ok = bus.mem_ready;
  end else begin : g_no_mem_wait
    assign mem_ok = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ctrl_reg  <= state_ctrl(S_IDLE);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next);
    end
  end

  alu_decoder u_alu_decoder (
    .aluop         (ctrl_reg.aluop),
    .funct         (bus.funct),
    .alucontrol    (alu_ctl),
    .illegal_funct (illegal_funct)
  );

  assign gate_ok = ~ctrl_reg.mem_gate | mem_ok;

  assign bus.iord       = ctrl_reg.iord;
  assign bus.memwrite   = ctrl_reg.memwrite;
  assign bus.irwrite    = ctrl_reg.irwrite & gate_ok;
  assign bus.pcen       = (ctrl_reg.pcwrite & gate_ok) | (ctrl_reg.branch & bus.zero);
  assign bus.regwrite   = ctrl_reg.regwrite;
  assign bus.regdst     = ctrl_reg.regdst;
  assign bus.memtoreg   = ctrl_reg.memtoreg;
  assign bus.alusrca    = ctrl_reg.alusrca;
  assign bus.alusrcb    = ctrl_reg.alusrcb;
  assign bus.pcsrc      = ctrl_reg.pcsrc;
  assign bus.alucontrol = alu_ctl;
  assign bus.retire     = ctrl_reg.retire & gate_ok;
  assign bus.illegal    = (ctrl_reg.chk_opcode & ~opcode_known(bus.opcode)) | illegal_funct;

endmodule
